mem_port_arbiter: RTL and testbench

- Shares the single byte-addressed, word-wide memory port between two requesters of the multi-cycle CPU: instruction fetch (I) and load/store (D).
- Each access runs IDLE -> ACCESS -> RESP:
  - latches the winning request;
  - drives the memory for exactly one cycle;
  - returns read data with a one-cycle ready pulse.
- Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single word-wide memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on a tie instead of favouring D.
module mem_port_arbiter #(
  parameter int MEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;
  localparam logic       GNT_I     = 1'b0;
  localparam logic       GNT_D     = 1'b1;
  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  logic [1:0]  state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_i_q, resp_i_d;
  logic        resp_d_q, resp_d_d;

  logic        pick_d;
  logic [31:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
  // On a tie the port that was not served last wins.
  assign pick_d = d_req && (!i_req || (last_grant_q == GNT_I));
`else
  assign pick_d = d_req;
`endif

  assign sel_addr = pick_d ? d_addr : i_addr;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    valid_d      = valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    resp_i_d     = 1'b0;
    resp_d_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          gnt_d   = pick_d ? GNT_D : GNT_I;
          addr_d  = sel_addr;
          we_d    = pick_d && d_we;
          wdata_d = d_wdata;
          valid_d = (sel_addr[1:0] == 2'b00) && (sel_addr <= MAX_ADDR);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Stores also capture mem_rd (pre-write word); the requester ignores it.
        rdata_d  = valid_q ? mem_rd : 32'd0;
        err_d    = !valid_q;
        resp_i_d = (gnt_q == GNT_I);
        resp_d_d = (gnt_q == GNT_D);
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        last_grant_d = gnt_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_I;
      last_grant_q <= GNT_D;
      addr_q       <= 32'd0;
      we_q         <= 1'b0;
      wdata_q      <= 32'd0;
      valid_q      <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      resp_i_q     <= 1'b0;
      resp_d_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      resp_i_q     <= resp_i_d;
      resp_d_q     <= resp_d_d;
    end
  end

  // Write enable derives from state_q so an async reset kills it immediately.
  assign mem_we = (state_q == ST_ACCESS) && we_q && valid_q;
  assign mem_a  = addr_q;
  assign mem_wd = wdata_q;

  assign i_ready = resp_i_q;
  assign i_rdata = resp_i_q ? rdata_q : 32'd0;
  assign i_err   = resp_i_q && err_q;
  assign d_ready = resp_d_q;
  assign d_rdata = resp_d_q ? rdata_q : 32'd0;
  assign d_err   = resp_d_q && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 100-byte big-endian memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ready, i_err, d_ready, d_err, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_a, mem_wd, mem_rd;

  logic [7:0]  mem [0:99];
  logic        load_mem;
  int          tests = 0;
  int          errors = 0;
  int          we_cycles = 0;

  mem_port_arbiter #(.MEM_BYTES(100)) dut (
    .clk(clk), .reset(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 100; k++) begin
        if (k == 0)      mem[k] <= 8'h8C;
        else if (k == 1) mem[k] <= 8'h01;
        else if (k == 2) mem[k] <= 8'h00;
        else if (k == 3) mem[k] <= 8'h04;
        else             mem[k] <= 8'(k * 3 + 1);
      end
    end else if (mem_we && mem_a <= 32'd96) begin
      mem[mem_a[6:0]]        <= mem_wd[31:24];
      mem[mem_a[6:0] + 7'd1] <= mem_wd[23:16];
      mem[mem_a[6:0] + 7'd2] <= mem_wd[15:8];
      mem[mem_a[6:0] + 7'd3] <= mem_wd[7:0];
    end
  end

  always_comb begin
    mem_rd = 32'd0;
    if (mem_a <= 32'd96)
      mem_rd = {mem[mem_a[6:0]], mem[mem_a[6:0] + 7'd1],
                mem[mem_a[6:0] + 7'd2], mem[mem_a[6:0] + 7'd3]};
  end

  always @(negedge clk) if (mem_we) we_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one access from IDLE; returns response and cycles until ready (0 = none).
  task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    bit got = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 1; k <= 10 && !got; k++) begin
      @(posedge clk); #1;
      if (is_d ? d_ready : i_ready) begin
        got = 1'b1; lat = k;
        rd = is_d ? d_rdata : i_rdata;
        er = is_d ? d_err : i_err;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    check("ready_pulse_end", {31'd0, is_d ? d_ready : i_ready}, 32'd0);
    $display("[TB] %s %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             is_d ? "D" : "I", we ? "ST" : "LD", addr, wd, rd, er, lat);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, we0, i_cyc, d_cyc, cnt;
  int          cyc [3];
  logic [31:0] exp_words [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_mem = 1'b1;
    i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_ready", {31'd0, i_ready}, 32'd0);
    check("rst_d_ready", {31'd0, d_ready}, 32'd0);
    check("rst_i_err",   {31'd0, i_err}, 32'd0);
    check("rst_d_err",   {31'd0, d_err}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    check("rst_mem_a",   mem_a, 32'd0);
    check("rst_mem_wd",  mem_wd, 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    load_mem = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fetch from address 0
    we0 = we_cycles;
    access(1'b0, 1'b0, 32'd0, 32'd0, rd, er, lat);
    check("fetch0_lat", 32'(lat), 32'd2);
    check("fetch0_data", rd, 32'h8C010004);
    check("fetch0_err", {31'd0, er}, 32'd0);
    check("fetch0_no_we", 32'(we_cycles - we0), 32'd0);

    // Store then load at address 8
    we0 = we_cycles;
    access(1'b1, 1'b1, 32'd8, 32'hDEADBEEF, rd, er, lat);
    check("st8_lat", 32'(lat), 32'd2);
    check("st8_err", {31'd0, er}, 32'd0);
    check("st8_we_cycles", 32'(we_cycles - we0), 32'd1);
    access(1'b1, 1'b0, 32'd8, 32'd0, rd, er, lat);
    check("ld8_data", rd, 32'hDEADBEEF);

    // Simultaneous requests
    i_req = 1'b1; i_addr = 32'd0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd4;
    i_cyc = 0; d_cyc = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (d_ready && d_req) begin
        d_cyc = k; check("tie_d_data", d_rdata, 32'h0D101316); d_req = 1'b0;
      end
      if (i_ready && i_req) begin
        i_cyc = k; check("tie_i_data", i_rdata, 32'h8C010004); i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    $display("[TB] tie: d_ready at +%0d, i_ready at +%0d", d_cyc, i_cyc);
`ifdef ARB_ROUND_ROBIN_EN
    check("tie_i_cycle", 32'(i_cyc), 32'd2);
    check("tie_d_cycle", 32'(d_cyc), 32'd5);
`else
    check("tie_d_cycle", 32'(d_cyc), 32'd2);
    check("tie_i_cycle", 32'(i_cyc), 32'd5);
`endif

    // Rejected stores, then boundary reads
    we0 = we_cycles;
    access(1'b1, 1'b1, 32'd6, 32'hCAFEF00D, rd, er, lat);
    check("st6_err", {31'd0, er}, 32'd1);
    check("st6_rdata", rd, 32'd0);
    access(1'b1, 1'b1, 32'd100, 32'hCAFEF00D, rd, er, lat);
    check("st100_err", {31'd0, er}, 32'd1);
    check("st100_rdata", rd, 32'd0);
    check("bad_st_no_we", 32'(we_cycles - we0), 32'd0);
    access(1'b1, 1'b0, 32'd4, 32'd0, rd, er, lat);
    check("ld4_data", rd, 32'h0D101316);
    check("ld4_err", {31'd0, er}, 32'd0);
    access(1'b1, 1'b0, 32'd96, 32'd0, rd, er, lat);
    check("ld96_data", rd, 32'h2124272A);
    check("ld96_err", {31'd0, er}, 32'd0);

    // Reset falls during ACCESS of a store to 12
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'd12; d_wdata = 32'h11111111;
    @(posedge clk); #1;
    check("abort_we_before", {31'd0, mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_after", {31'd0, mem_we}, 32'd0);
    d_req = 1'b0;
    @(posedge clk); #1;
    check("abort_no_ready", {31'd0, d_ready}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_no_ready2", {31'd0, d_ready}, 32'd0);
    $display("[TB] D ST addr=0000000c aborted by reset");
    access(1'b1, 1'b0, 32'd12, 32'd0, rd, er, lat);
    check("ld12_lat", 32'(lat), 32'd2);
    check("ld12_data", rd, 32'h25282B2E);

    // Fetch held high for three back-to-back accesses
    exp_words[0] = 32'h8C010004;
    exp_words[1] = 32'h0D101316;
    exp_words[2] = 32'hDEADBEEF;
    cnt = 0;
    cyc[0] = 0; cyc[1] = 0; cyc[2] = 0;
    i_req = 1'b1; i_addr = 32'd0;
    for (int k = 1; k <= 20 && cnt < 3; k++) begin
      @(posedge clk); #1;
      if (i_ready) begin
        check("burst_data", i_rdata, exp_words[cnt]);
        $display("[TB] I LD addr=%h -> rdata=%h at +%0d", i_addr, i_rdata, k);
        cyc[cnt] = k;
        cnt++;
        i_addr = 32'(cnt * 4);
        if (cnt == 3) i_req = 1'b0;
      end
    end
    i_req = 1'b0;
    check("burst_count", 32'(cnt), 32'd3);
    check("burst_first", 32'(cyc[0]), 32'd2);
    check("burst_gap1", 32'(cyc[1] - cyc[0]), 32'd3);
    check("burst_gap2", 32'(cyc[2] - cyc[1]), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
